mix_mem_arbiter: RTL and testbench

- Single-port arbiter for the 4096 x 31-bit MIX core memory.
- Shares the one read/write port between the CPU execution path and NDEV device channels: IN store, OUT load and SRAM block transfer.
- CPU has fixed priority. Devices rotate round-robin among themselves. A per-device aging counter forces a device ahead of the CPU once it has waited MAX_WAIT cycles.
- Sits between the core/device FSMs and the memory array. Read latency is 1 cycle.

---
 rtl/mix_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mix_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_mem_arbiter.sv
// mix_mem_arbiter
// ---------------
// Single-port arbiter in front of the 4096 x 31-bit MIX core memory. The CPU
// execution path and NDEV device channels (0=IN, 1=OUT, 2=SRAM) share the one
// read/write port.
//
// Grant policy, evaluated every cycle from the live requests and the
// registered state:
//   1. A device that has been denied for MAX_WAIT or more consecutive cycles
//      is urgent; urgent devices win over everything, round-robin from rr_ptr.
//   2. Otherwise the CPU wins when it requests.
//   3. Otherwise a requesting device wins, round-robin from rr_ptr.
//
// Handshake: a requester raises req with we/addr/wdata and holds all of them
// stable until it sees its gnt. The access is performed in the gnt cycle; the
// requester may drop or change the request on the following cycle. A read
// grant is answered one cycle later by a one-cycle rvalid pulse to that same
// requester, while rdata carries the memory output. Writes return no rvalid.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request
//   cpu_gnt, cpu_stall         CPU grant this cycle, request pending but denied
//   cpu_rvalid                 CPU read data valid on rdata
//   dev_req/we                 per-device request and write flag
//   dev_addr, dev_wdata        packed per-device address / write data
//   dev_gnt, dev_rvalid        one-hot device grant / read-data valid
//   rdata                      shared read data (= mem_rdata)
//   mem_addr/we/wdata          memory port, driven by the granted requester
//   mem_rdata                  memory output, 1 cycle after the address
module mix_mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 31,
    parameter int NDEV     = 3,
    parameter int MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [AW-1:0]      cpu_addr,
    input  logic [DW-1:0]      cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_stall,
    output logic               cpu_rvalid,
    input  logic [NDEV-1:0]    dev_req,
    input  logic [NDEV-1:0]    dev_we,
    input  logic [NDEV*AW-1:0] dev_addr,
    input  logic [NDEV*DW-1:0] dev_wdata,
    output logic [NDEV-1:0]    dev_gnt,
    output logic [NDEV-1:0]    dev_rvalid,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_we,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int PW = (NDEV > 1) ? $clog2(NDEV) : 1;

    // Registered state
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]      wait_cnt_q [NDEV];
    logic [3:0]      wait_cnt_d [NDEV];
    logic            cpu_rvalid_q, cpu_rvalid_d;
    logic [NDEV-1:0] dev_rvalid_q, dev_rvalid_d;

    // Arbitration intermediates
    logic [NDEV-1:0] urgent;
    logic            urg_found, req_found;
    logic [PW-1:0]   urg_idx, req_idx;
    logic            dev_sel;
    logic [PW-1:0]   dev_idx;
    int              cand;

    always_comb begin
        for (int i = 0; i < NDEV; i++) begin
            urgent[i] = dev_req[i] & (wait_cnt_q[i] >= 4'(MAX_WAIT));
        end
    end

    // Two round-robin searches starting at rr_ptr: one over urgent devices,
    // one over all requesting devices. The first hit in rotation order wins.
    always_comb begin
        urg_found = 1'b0;
        urg_idx   = '0;
        req_found = 1'b0;
        req_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NDEV; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NDEV) begin
                cand = cand - NDEV;
            end
            if (!urg_found && urgent[cand]) begin
                urg_found = 1'b1;
                urg_idx   = PW'(cand);
            end
            if (!req_found && dev_req[cand]) begin
                req_found = 1'b1;
                req_idx   = PW'(cand);
            end
        end
    end

    // Grant selection; nothing is granted while reset is high.
    always_comb begin
        cpu_gnt = 1'b0;
        dev_sel = 1'b0;
        dev_idx = '0;
        dev_gnt = '0;
        if (!reset) begin
            if (urg_found) begin
                dev_sel = 1'b1;
                dev_idx = urg_idx;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (req_found) begin
                dev_sel = 1'b1;
                dev_idx = req_idx;
            end
            if (dev_sel) begin
                dev_gnt[dev_idx] = 1'b1;
            end
        end
    end

    // Memory port mux. With no grant the port is parked at address 0, no write.
    // Since grants are suppressed during reset, mem_we is also 0 then.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dev_sel) begin
            mem_addr  = dev_addr[int'(dev_idx)*AW +: AW];
            mem_we    = dev_we[dev_idx];
            mem_wdata = dev_wdata[int'(dev_idx)*DW +: DW];
        end
    end

    // Next-state logic
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (dev_sel) begin
            rr_ptr_d = (dev_idx == PW'(NDEV - 1)) ? '0 : dev_idx + PW'(1);
        end

        // Aging counts consecutive denied cycles and saturates at 15.
        for (int i = 0; i < NDEV; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!dev_req[i] || dev_gnt[i]) begin
                wait_cnt_d[i] = 4'd0;
            end else if (wait_cnt_q[i] != 4'hF) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 4'd1;
            end
        end

        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        dev_rvalid_d = dev_gnt & ~dev_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            cpu_rvalid_q <= 1'b0;
            dev_rvalid_q <= '0;
            for (int i = 0; i < NDEV; i++) begin
                wait_cnt_q[i] <= 4'd0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dev_rvalid_q <= dev_rvalid_d;
            for (int i = 0; i < NDEV; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dev_rvalid = dev_rvalid_q;
    assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mix_mem_arbiter.sv
// Testbench for mix_mem_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural model of the grant
// rules, aging counters and read-data return.
module tb_mix_mem_arbiter;

    localparam int AW       = 12;
    localparam int DW       = 31;
    localparam int NDEV     = 3;
    localparam int MAX_WAIT = 8;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT signals
    logic               cpu_req, cpu_we;
    logic [AW-1:0]      cpu_addr;
    logic [DW-1:0]      cpu_wdata;
    logic               cpu_gnt, cpu_stall, cpu_rvalid;
    logic [NDEV-1:0]    dev_req, dev_we, dev_gnt, dev_rvalid;
    logic [NDEV*AW-1:0] dev_addr;
    logic [NDEV*DW-1:0] dev_wdata;
    logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]      mem_addr;
    logic               mem_we;

    mix_mem_arbiter #(.AW(AW), .DW(DW), .NDEV(NDEV), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory array behind the arbiter (registered read, 1-cycle latency)
    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference model state
    logic [DW-1:0]   ref_mem [0:4095];
    int              m_rr;
    int              m_wait [NDEV];
    bit              m_cpu_rv;
    logic [NDEV-1:0] m_dev_rv;
    logic [DW-1:0]   exp_q [$];
    bit              last_g_cpu;
    int              last_g_dev;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Evaluate the grant rules on the current inputs, compare every output,
    // then advance the model as the clock edge will.
    task automatic check_and_update();
        bit              g_cpu;
        int              g_dev;
        int              d;
        logic [NDEV-1:0] e_dgnt;
        logic [AW-1:0]   e_addr;
        logic            e_we;
        logic [DW-1:0]   e_wd;
        logic [DW-1:0]   e_rd;
        g_cpu = 0;
        g_dev = -1;
        if (!reset) begin
            for (int k = 0; k < NDEV; k++) begin
                d = (m_rr + k) % NDEV;
                if (g_dev < 0 && dev_req[d] && m_wait[d] >= MAX_WAIT) g_dev = d;
            end
            if (g_dev < 0) begin
                if (cpu_req) g_cpu = 1;
                else begin
                    for (int k = 0; k < NDEV; k++) begin
                        d = (m_rr + k) % NDEV;
                        if (g_dev < 0 && dev_req[d]) g_dev = d;
                    end
                end
            end
        end
        e_dgnt = '0; e_addr = '0; e_we = 1'b0; e_wd = '0;
        if (g_cpu) begin
            e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata;
        end else if (g_dev >= 0) begin
            e_dgnt[g_dev] = 1'b1;
            e_addr = dev_addr[g_dev*AW +: AW];
            e_we   = dev_we[g_dev];
            e_wd   = dev_wdata[g_dev*DW +: DW];
        end
        check_eq("cpu_gnt", 64'(cpu_gnt), 64'(g_cpu));
        check_eq("dev_gnt", 64'(dev_gnt), 64'(e_dgnt));
        check_eq("cpu_stall", 64'(cpu_stall), 64'(cpu_req & ~g_cpu));
        check_eq("mem_we", 64'(mem_we), 64'(e_we));
        check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
        check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        check_eq("cpu_rvalid", 64'(cpu_rvalid), 64'(m_cpu_rv));
        check_eq("dev_rvalid", 64'(dev_rvalid), 64'(m_dev_rv));
        if (m_cpu_rv || m_dev_rv != '0) begin
            e_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check_eq("rdata", 64'(rdata), 64'(e_rd));
        end

        if (reset) begin
            m_rr = 0;
            for (int i = 0; i < NDEV; i++) m_wait[i] = 0;
            m_cpu_rv = 0;
            m_dev_rv = '0;
            exp_q.delete();
        end else begin
            m_cpu_rv = g_cpu && !cpu_we;
            m_dev_rv = '0;
            if (g_dev >= 0 && !dev_we[g_dev]) m_dev_rv[g_dev] = 1'b1;
            if ((g_cpu || g_dev >= 0) && !e_we) exp_q.push_back(ref_mem[e_addr]);
            if (e_we) ref_mem[e_addr] = e_wd;
            if (g_dev >= 0) m_rr = (g_dev + 1) % NDEV;
            for (int i = 0; i < NDEV; i++) begin
                if (!dev_req[i] || g_dev == i) m_wait[i] = 0;
                else if (m_wait[i] < 15) m_wait[i]++;
            end
        end
        last_g_cpu = g_cpu;
        last_g_dev = g_dev;
    endtask

    // One clock: inputs already driven; check at negedge, then step past posedge.
    task automatic cycle(input int n = 1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_and_update();
            @(posedge clk);
            #1;
        end
    endtask

    // Driver tasks
    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dev_req = '0; dev_we = '0; dev_addr = '0; dev_wdata = '0;
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    endtask

    task automatic set_dev(input int i, input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        dev_req[i] = req; dev_we[i] = we;
        dev_addr[i*AW +: AW] = a;
        dev_wdata[i*DW +: DW] = wd;
    endtask

    task automatic random_step();
        if (!cpu_req || last_g_cpu)
            set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    AW'($urandom_range(0, 4095)), DW'($urandom));
        for (int i = 0; i < NDEV; i++) begin
            if (!dev_req[i] || last_g_dev == i)
                set_dev(i, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        AW'($urandom_range(0, 4095)), DW'($urandom));
        end
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        m_rr = 0; m_cpu_rv = 0; m_dev_rv = '0;
        for (int i = 0; i < NDEV; i++) m_wait[i] = 0;
        last_g_cpu = 0; last_g_dev = -1;
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;

        // Requests during reset must not be granted
        set_cpu(1, 1, 12'h055, 31'h1234);
        for (int i = 0; i < NDEV; i++) set_dev(i, 1, 1, AW'(i), DW'(i));
        cycle(2);
        clear_inputs();
        cycle();
        reset = 1'b0;

        // Idle
        cycle(2);

        // CPU read of 0x123
        set_cpu(1, 0, 12'h123, '0);
        cycle();
        clear_inputs();
        cycle(2);

        // Contention: CPU and all devices held; aging lets devices in
        for (int i = 0; i < NDEV; i++) set_dev(i, 1, 0, AW'(12'h200 + i), '0);
        set_cpu(1, 0, 12'h300, '0);
        cycle(14);
        clear_inputs();
        cycle(2);

        // Round robin between devices 0 and 2
        set_dev(0, 1, 0, 12'h010, '0);
        set_dev(2, 1, 0, 12'h012, '0);
        cycle(4);
        clear_inputs();
        cycle();

        // Move rr_ptr to 2 via a grant to device 1, then check wrap to 0
        set_dev(1, 1, 0, 12'h021, '0);
        cycle();
        set_dev(0, 1, 0, 12'h020, '0);
        cycle();
        clear_inputs();
        cycle(2);

        // Write path at the top address with an all-ones word, then read back
        set_dev(2, 1, 1, 12'hFFF, 31'h7FFFFFFF);
        cycle();
        clear_inputs();
        cycle();
        set_cpu(1, 0, 12'hFFF, '0);
        cycle();
        clear_inputs();
        cycle(2);

        // Reset mid-read with device 1 held through reset
        set_cpu(1, 0, 12'h0AB, '0);
        cycle();
        cpu_req = 0;
        reset = 1'b1;
        set_dev(1, 1, 0, 12'h0CD, '0);
        cycle(2);
        reset = 1'b0;
        cycle();
        clear_inputs();
        cycle(2);

        // Long contention run
        set_cpu(1, 0, 12'h400, '0);
        for (int i = 0; i < NDEV; i++) set_dev(i, 1, 0, AW'(12'h500 + i), '0);
        cycle(40);
        clear_inputs();
        cycle(2);

        // Randomized traffic
        last_g_cpu = 0; last_g_dev = -1;
        for (int n = 0; n < 600; n++) random_step();
        clear_inputs();
        cycle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
